// File: rtl/seq_rr_hold_reg_arbiter_if.sv
// Request/holding-register bus between the requesters, the arbiter and the downstream consumer.
interface seq_rr_hold_reg_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] data;
    logic [NUM_REQ-1:0]        gnt;
    logic [DATA_W-1:0]         q;
    logic                      q_valid;
    logic                      q_ready;
    logic [IDX_W-1:0]          q_src;

    // Environment side: requesters plus the downstream consumer.
    modport master (
        output req, data, q_ready,
        input  gnt, q, q_valid, q_src
    );

    modport slave (
        input  req, data, q_ready,
        output gnt, q, q_valid, q_src
    );
endinterface

// File: rtl/seq_rr_hold_reg_arbiter.sv
// Round-robin arbiter loading one shared holding register and offering it downstream via valid/ready.
// Define SEQ_RR_HOLD_REG_ARBITER_BYPASS_EN to re-arbitrate on the handshake cycle (one transfer per cycle).
module seq_rr_hold_reg_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    seq_rr_hold_reg_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE, FULL} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  q_q, q_d;
    logic [IDX_W-1:0]   q_src_q, q_src_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic [DATA_W-1:0]  slice [NUM_REQ];
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;
    int                 arb_idx;
    logic               load;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign slice[i] = bus.data[i*DATA_W +: DATA_W];
    end

    // Scan requests starting at the pointer, wrapping; the first set bit wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        arb_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_idx = (int'(ptr_q) + k) % NUM_REQ;
            cand    = IDX_W'(arb_idx);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        q_src_d = q_src_q;
        ptr_d   = ptr_q;
        load    = 1'b0;
        bus.gnt = '0;

        case (state_q)
            IDLE: begin
                load = win_found;
            end
            FULL: begin
                if (bus.q_ready) begin
`ifdef SEQ_RR_HOLD_REG_ARBITER_BYPASS_EN
                    if (win_found) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (load && !rst) begin
            bus.gnt[win_idx] = 1'b1;
            q_d     = slice[win_idx];
            q_src_d = win_idx;
            ptr_d   = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
            state_d = FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            q_src_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            q_src_q <= q_src_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.q       = q_q;
    assign bus.q_src   = q_src_q;
    assign bus.q_valid = (state_q == FULL);
endmodule

// File: tb/tb_seq_rr_hold_reg_arbiter.sv
// Self-checking bench: reference model plus a scoreboard of captured payloads popped on each handshake.
module tb_seq_rr_hold_reg_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int IDX_W   = $clog2(NUM_REQ);

    logic clk;
    logic rst;

    seq_rr_hold_reg_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    seq_rr_hold_reg_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic              m_valid;
    logic [DATA_W-1:0] m_q;
    logic [IDX_W-1:0]  m_src;
    int                m_ptr;
    logic [15:0]       sb [$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock: compare at the falling edge, then advance the model to the next rising edge.
    task automatic stepCycle();
        int          w;
        int          idx;
        bit          found;
        bit          can_arb;
        logic [NUM_REQ-1:0] exp_gnt;
        logic [15:0] ent;
        @(negedge clk);
        found = 0;
        w     = 0;
        idx   = m_ptr;
        repeat (NUM_REQ) begin
            if (!found && bus.req[idx]) begin
                found = 1;
                w     = idx;
            end
            idx = (idx == NUM_REQ-1) ? 0 : idx + 1;
        end
`ifdef SEQ_RR_HOLD_REG_ARBITER_BYPASS_EN
        can_arb = !rst && (!m_valid || bus.q_ready);
`else
        can_arb = !rst && !m_valid;
`endif
        exp_gnt = (found && can_arb) ? NUM_REQ'(1 << w) : '0;
        checkOutput("gnt", 32'(bus.gnt), 32'(exp_gnt));
        checkOutput("q_valid", 32'(bus.q_valid), 32'(m_valid));
        checkOutput("q", 32'(bus.q), 32'(m_q));
        checkOutput("q_src", 32'(bus.q_src), 32'(m_src));
        if (m_valid && bus.q_ready && !rst) begin
            if (sb.size() == 0) begin
                checkOutput("sb_empty", 32'd0, 32'd1);
            end else begin
                ent = sb.pop_front();
                checkOutput("sb_q", 32'(bus.q), 32'(ent[7:0]));
                checkOutput("sb_src", 32'(bus.q_src), 32'(ent[15:8]));
            end
        end
        if (rst) begin
            m_valid = 0; m_q = '0; m_src = '0; m_ptr = 0;
            sb.delete();
        end else if (found && can_arb) begin
            m_q     = bus.data[w*DATA_W +: DATA_W];
            m_src   = IDX_W'(w);
            m_ptr   = (w == NUM_REQ-1) ? 0 : w + 1;
            m_valid = 1;
            sb.push_back({8'(w), m_q});
        end else if (m_valid && bus.q_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic [NUM_REQ-1:0] rq,
                                 input logic [NUM_REQ*DATA_W-1:0] d, input logic rdy, input int cycles);
        rst         = r;
        bus.req     = rq;
        bus.data    = d;
        bus.q_ready = rdy;
        repeat (cycles) stepCycle();
    endtask

    initial begin
        m_valid = 0; m_q = '0; m_src = '0; m_ptr = 0;
        rst = 1'b1; bus.req = '0; bus.data = '0; bus.q_ready = 1'b0;
        @(posedge clk); #1;

        $display("[TB] test 1: reset then single requester");
        applyStimulus(1'b1, 4'b0100, 32'h00A5_0000, 1'b0, 2);
        rst = 1'b0;
        #1;
        checkOutput("t1_gnt", 32'(bus.gnt), 32'h4);
        stepCycle();
        checkOutput("t1_q", 32'(bus.q), 32'hA5);
        checkOutput("t1_valid", 32'(bus.q_valid), 32'h1);
        checkOutput("t1_src", 32'(bus.q_src), 32'h2);
        applyStimulus(1'b0, 4'b1111, 32'h0, 1'b1, 1);
        applyStimulus(1'b0, 4'b1111, 32'h0, 1'b0, 1);
        checkOutput("t1_ptr3", 32'(bus.q_src), 32'h3);

        $display("[TB] test 2: round-robin all requesters");
        applyStimulus(1'b1, 4'b0000, 32'h0, 1'b0, 1);
        applyStimulus(1'b0, 4'b1111, 32'h1312_1110, 1'b1, 10);

        $display("[TB] test 3: backpressure");
        applyStimulus(1'b1, 4'b0000, 32'h0, 1'b0, 1);
        applyStimulus(1'b0, 4'b0001, 32'h0000_003C, 1'b0, 1);
        applyStimulus(1'b0, 4'b0011, 32'h0000_553C, 1'b0, 5);
        checkOutput("t3_q_held", 32'(bus.q), 32'h3C);
        applyStimulus(1'b0, 4'b0011, 32'h0000_553C, 1'b1, 4);

        $display("[TB] test 4: pointer wrap");
        applyStimulus(1'b1, 4'b0000, 32'h0, 1'b0, 1);
        applyStimulus(1'b0, 4'b1000, 32'h7700_0000, 1'b1, 2);
        applyStimulus(1'b0, 4'b1001, 32'h7700_0066, 1'b1, 4);

        $display("[TB] test 5: reset mid-operation");
        applyStimulus(1'b1, 4'b0000, 32'h0, 1'b0, 1);
        applyStimulus(1'b0, 4'b0001, 32'h0000_00FF, 1'b0, 2);
        applyStimulus(1'b1, 4'b0010, 32'h0000_42FF, 1'b0, 1);
        checkOutput("t5_q", 32'(bus.q), 32'h0);
        checkOutput("t5_valid", 32'(bus.q_valid), 32'h0);
        rst = 1'b0;
        #1;
        checkOutput("t5_gnt", 32'(bus.gnt), 32'h2);
        applyStimulus(1'b0, 4'b0010, 32'h0000_42FF, 1'b1, 2);

        $display("[TB] test 6: continuous requests with ready held");
        applyStimulus(1'b1, 4'b0000, 32'h0, 1'b0, 1);
        applyStimulus(1'b0, 4'b0011, 32'h0000_B2A1, 1'b1, 8);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0), NUM_REQ'($urandom_range(0, 15)),
                          32'($urandom), 1'($urandom_range(0, 1)), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
